// File: rtl/uart_pkg.sv
// Shared types, limits and helpers for the configurable UART transmitter.
package uart_pkg;

    localparam int UART_MIN_BITS = 5;
    localparam int UART_MAX_BITS = 9;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Pin encoding 2'b11 is treated as "no parity", same as 2'b00.
    function automatic parity_e decode_parity(input logic [1:0] code);
        parity_e mode;
        case (code)
            2'b01:   mode = EVEN;
            2'b10:   mode = ODD;
            default: mode = NONE;
        endcase
        return mode;
    endfunction

    function automatic logic [3:0] clamp_nbits(input logic [3:0] nbits, input int max_bits);
        logic [3:0] n;
        n = nbits;
        if (nbits < 4'(UART_MIN_BITS)) begin
            n = 4'(UART_MIN_BITS);
        end else if (nbits > 4'(max_bits)) begin
            n = 4'(max_bits);
        end
        return n;
    endfunction

    function automatic logic calc_parity(input logic [UART_MAX_BITS-1:0] data,
                                         input logic [3:0]               nbits,
                                         input parity_e                  mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < UART_MAX_BITS; i++) begin
            if (4'(i) < nbits) begin
                p = p ^ data[i];
            end
        end
        return (mode == ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// Single-entry holding register between the producer handshake and the transmit FSM.
// Handshake: a word and its config transfer on a rising edge where TxValid && TxReady;
// TxReady depends only on the register state, never on TxValid, and TxValid may stay high.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    input  logic [3:0]        NBits,
    input  logic [1:0]        Parity,
    input  logic              Stop2,
    output logic              TxReady,
    input  logic              pop,
    output logic              hold_full,
    output logic [DATA_W-1:0] hold_data,
    output logic [3:0]        hold_nbits,
    output parity_e           hold_par,
    output logic              hold_stop2
);

    logic xfer;

    assign TxReady = !hold_full;
    assign xfer    = TxValid && TxReady;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            hold_nbits <= 4'(UART_MIN_BITS);
            hold_par   <= NONE;
            hold_stop2 <= 1'b0;
        end else begin
            if (pop) begin
                hold_full <= 1'b0;
            end
            if (xfer) begin
                hold_full  <= 1'b1;
                hold_data  <= TxData;
                hold_nbits <= clamp_nbits(NBits, DATA_W);
                hold_par   <= decode_parity(Parity);
                hold_stop2 <= Stop2;
            end
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime data length, parity and stop bits, paced by an
// oversampling Tick enable; back-to-back frames are fed from a one-entry hold register.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tick,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    input  logic [3:0]        NBits,
    input  logic [1:0]        Parity,
    input  logic              Stop2,
    output logic              Tx,
    output logic              Busy,
    output logic              TxDone,
    output tx_state_e         DbgState
);

    generate
        if (DATA_W < UART_MIN_BITS || DATA_W > UART_MAX_BITS) begin : g_bad_data_w
            $error("uart_tx_cfg: DATA_W must lie in 5..9");
        end
        if (OVS < 4 || OVS > 64) begin : g_bad_ovs
            $error("uart_tx_cfg: OVS must lie in 4..64");
        end
    endgenerate

    localparam int             TW        = $clog2(OVS);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVS - 1);

    tx_state_e               state;
    logic [TW-1:0]           tick_cnt;
    logic [DATA_W-1:0]       shifter;
    logic [3:0]              bit_cnt;
    logic [3:0]              nbits_r;
    logic                    par_en;
    logic                    par_bit;
    logic                    stop2_r;
    logic                    stop_left;

    logic                    hold_full;
    logic [DATA_W-1:0]       hold_data;
    logic [3:0]              hold_nbits;
    parity_e                 hold_par;
    logic                    hold_stop2;
    logic [UART_MAX_BITS-1:0] hold_ext;

    logic                    bit_end;
    logic                    last_stop;
    logic                    pop;

    uart_tx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .Clk        (Clk),
        .Rst        (Rst),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .NBits      (NBits),
        .Parity     (Parity),
        .Stop2      (Stop2),
        .TxReady    (TxReady),
        .pop        (pop),
        .hold_full  (hold_full),
        .hold_data  (hold_data),
        .hold_nbits (hold_nbits),
        .hold_par   (hold_par),
        .hold_stop2 (hold_stop2)
    );

    always_comb begin
        hold_ext = '0;
        hold_ext[DATA_W-1:0] = hold_data;
    end

    assign bit_end   = Tick && (tick_cnt == TICK_LAST);
    assign last_stop = (state == STOP) && bit_end && !stop_left;
    // A held frame loads either from IDLE or straight out of the last stop bit.
    assign pop       = hold_full && ((state == IDLE) || last_stop);
    assign DbgState  = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            Tx        <= 1'b1;
            Busy      <= 1'b0;
            TxDone    <= 1'b0;
            tick_cnt  <= '0;
            shifter   <= '0;
            bit_cnt   <= '0;
            nbits_r   <= 4'(UART_MIN_BITS);
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2_r   <= 1'b0;
            stop_left <= 1'b0;
        end else begin
            TxDone <= 1'b0;
            if (pop) begin
                state     <= START;
                Tx        <= 1'b0;
                Busy      <= 1'b1;
                TxDone    <= last_stop;
                tick_cnt  <= '0;
                shifter   <= hold_data;
                bit_cnt   <= '0;
                nbits_r   <= hold_nbits;
                par_en    <= (hold_par != NONE);
                par_bit   <= calc_parity(hold_ext, hold_nbits, hold_par);
                stop2_r   <= hold_stop2;
                stop_left <= 1'b0;
            end else if (state != IDLE && Tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state   <= DATA;
                            Tx      <= shifter[0];
                            shifter <= shifter >> 1;
                            bit_cnt <= 4'd1;
                        end
                        DATA: begin
                            // bit_cnt counts data bits already placed on the line.
                            if (bit_cnt == nbits_r) begin
                                if (par_en) begin
                                    state <= PARITY;
                                    Tx    <= par_bit;
                                end else begin
                                    state     <= STOP;
                                    Tx        <= 1'b1;
                                    stop_left <= stop2_r;
                                end
                            end else begin
                                Tx      <= shifter[0];
                                shifter <= shifter >> 1;
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        PARITY: begin
                            state     <= STOP;
                            Tx        <= 1'b1;
                            stop_left <= stop2_r;
                        end
                        STOP: begin
                            if (stop_left) begin
                                stop_left <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                Busy   <= 1'b0;
                                TxDone <= 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            Tx    <= 1'b1;
                            Busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames plus randomized traffic against a frame-list model.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Tick = 1'b0;
    logic [DATA_W-1:0] TxData = '0;
    logic              TxValid = 1'b0;
    logic              TxReady;
    logic [3:0]        NBits = 4'd8;
    logic [1:0]        Parity = 2'b00;
    logic              Stop2 = 1'b0;
    logic              Tx;
    logic              Busy;
    logic              TxDone;
    tx_state_e         DbgState;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int done_cnt = 0;
    int tick_mode = 0;

    // model state
    frame_t m_hold_q[$];
    frame_t m_cur;
    bit     m_in_frame = 1'b0;
    int     m_bit_idx = 0;
    int     m_tcnt = 0;
    logic   exp_tx = 1'b1;
    logic   exp_busy = 1'b0;
    logic   exp_done = 1'b0;
    logic   exp_ready = 1'b1;

    uart_tx_cfg #(
        .DATA_W (DATA_W),
        .OVS    (OVS)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .TxData   (TxData),
        .TxValid  (TxValid),
        .TxReady  (TxReady),
        .NBits    (NBits),
        .Parity   (Parity),
        .Stop2    (Stop2),
        .Tx       (Tx),
        .Busy     (Busy),
        .TxDone   (TxDone),
        .DbgState (DbgState)
    );

    // clock / tick generation
    initial forever #5 Clk = ~Clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge Clk);
            if (tick_mode == 0) begin
                Tick = (div == 3);
                div  = (div + 1) % 4;
            end else begin
                Tick = ($urandom_range(0, 1) == 0);
            end
        end
    end

    // The line sequence of one frame, index 0 is the start bit.
    function automatic frame_t build_frame(input logic [7:0] d, input logic [3:0] nb,
                                           input logic [1:0] p, input logic s2);
        frame_t f;
        int     n;
        int     k;
        logic   pb;
        n = (nb < 5) ? 5 : ((nb > DATA_W) ? DATA_W : int'(nb));
        f.bits = '0;
        k = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            k++;
        end
        if (p == 2'b01 || p == 2'b10) begin
            pb = ($countones(32'(d) & ((32'd1 << n) - 32'd1)) % 2) == 1;
            if (p == 2'b10) pb = !pb;
            f.bits[k] = pb;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end else begin
            passes++;
        end
    endtask

    // behavioural model: advances on each edge using pre-edge inputs
    always @(posedge Clk or posedge Rst) begin
        bit ld;
        bit xfer;
        if (Rst) begin
            m_hold_q.delete();
            m_in_frame = 1'b0;
            m_bit_idx  = 0;
            m_tcnt     = 0;
            exp_tx     = 1'b1;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            exp_ready  = 1'b1;
        end else begin
            xfer     = TxValid && (m_hold_q.size() == 0);
            exp_done = 1'b0;
            ld       = 1'b0;
            if (m_in_frame) begin
                if (Tick) begin
                    m_tcnt++;
                    if (m_tcnt == OVS) begin
                        m_tcnt = 0;
                        m_bit_idx++;
                        if (m_bit_idx == m_cur.len) begin
                            exp_done   = 1'b1;
                            m_in_frame = 1'b0;
                            ld         = (m_hold_q.size() != 0);
                        end
                    end
                end
            end else begin
                ld = (m_hold_q.size() != 0);
            end
            if (ld) begin
                m_cur      = m_hold_q.pop_front();
                m_in_frame = 1'b1;
                m_bit_idx  = 0;
                m_tcnt     = 0;
            end
            if (xfer) m_hold_q.push_back(build_frame(TxData, NBits, Parity, Stop2));
            exp_tx    = m_in_frame ? m_cur.bits[m_bit_idx] : 1'b1;
            exp_busy  = m_in_frame;
            exp_ready = (m_hold_q.size() == 0);
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge Clk) begin
        if (!Rst) begin
            checks++;
            if ({Tx, Busy, TxDone, TxReady} !== {exp_tx, exp_busy, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL line @%0t: tx/busy/done/ready got %b want %b", $time,
                         {Tx, Busy, TxDone, TxReady}, {exp_tx, exp_busy, exp_done, exp_ready});
            end else begin
                passes++;
            end
            if (TxDone === 1'b1) done_cnt++;
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] p, input logic s2);
        int   n;
        logic acc;
        TxData  = d;
        NBits   = nb;
        Parity  = p;
        Stop2   = s2;
        TxValid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 4000) begin
            @(posedge Clk);
            acc = TxReady;
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    task automatic wait_idle();
        int n;
        TxValid = 1'b0;
        n = 0;
        while ((m_in_frame || m_hold_q.size() != 0) && n < 8000) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 8000) check("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b0;
        @(negedge Clk);
        #1;
        check("reset_outputs", {28'd0, Tx, TxReady, Busy, TxDone}, 32'b1100);
        check("reset_state", 32'(DbgState), 32'(IDLE));

        // pin the frame model to hand-derived line sequences
        begin
            frame_t f;
            f = build_frame(8'h55, 4'd8, 2'b00, 1'b0);
            check("model_8n1", {8'(f.len), f.bits}, {8'd10, 16'h02AA});
            f = build_frame(8'h41, 4'd7, 2'b01, 1'b1);
            check("model_7e2", {8'(f.len), f.bits}, {8'd11, 16'h0682});
            f = build_frame(8'h41, 4'd7, 2'b10, 1'b1);
            check("model_7o2", {8'(f.len), f.bits}, {8'd11, 16'h0782});
            f = build_frame(8'hFF, 4'd3, 2'b00, 1'b0);
            check("model_clamp_lo", {8'(f.len), f.bits}, {8'd7, 16'h007E});
            f = build_frame(8'hC3, 4'd15, 2'b00, 1'b0);
            check("model_clamp_hi", {8'(f.len), f.bits}, {8'd10, 16'h0386});
        end

        // 8N1
        tick_mode = 0;
        d0 = done_cnt;
        send(8'h55, 4'd8, 2'b00, 1'b0);
        wait_idle();
        check("done_8n1", 32'(done_cnt - d0), 32'd1);
        check("busy_after_8n1", {31'd0, Busy}, 32'd0);

        // 7E2 and 7O2
        d0 = done_cnt;
        send(8'h41, 4'd7, 2'b01, 1'b1);
        wait_idle();
        send(8'h41, 4'd7, 2'b10, 1'b1);
        wait_idle();
        check("done_7x2", 32'(done_cnt - d0), 32'd2);

        // back-to-back
        d0 = done_cnt;
        send(8'hA5, 4'd8, 2'b00, 1'b0);
        send(8'h3C, 4'd8, 2'b00, 1'b0);
        wait_idle();
        check("done_b2b", 32'(done_cnt - d0), 32'd2);

        // backpressure, valid held across three words
        d0 = done_cnt;
        send(8'h11, 4'd8, 2'b01, 1'b0);
        send(8'h22, 4'd6, 2'b10, 1'b1);
        send(8'h33, 4'd5, 2'b00, 1'b0);
        wait_idle();
        check("done_backpressure", 32'(done_cnt - d0), 32'd3);

        // NBits clamp
        send(8'hFF, 4'd3, 2'b00, 1'b0);
        wait_idle();
        send(8'hC3, 4'd15, 2'b00, 1'b0);
        wait_idle();

        // reset mid-frame with a word held
        send(8'h96, 4'd8, 2'b00, 1'b0);
        send(8'h5A, 4'd8, 2'b00, 1'b0);
        TxValid = 1'b0;
        n = 0;
        while (!(m_in_frame && m_bit_idx == 4) && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        check("reach_bit4", {31'd0, m_in_frame}, 32'd1);
        d0 = done_cnt;
        #1 Rst = 1'b1;
        #1;
        check("rst_midframe", {28'd0, Tx, TxReady, Busy, TxDone}, 32'b1100);
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        repeat (200) @(negedge Clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'h3A, 4'd8, 2'b01, 1'b0);
        wait_idle();
        check("rst_clean_frame", 32'(done_cnt - d0), 32'd1);

        // randomized traffic, random tick spacing, config churn while idle
        tick_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
            if (gap != 0) TxValid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                TxData = 8'($urandom_range(0, 255));
                NBits  = 4'($urandom_range(0, 15));
                Parity = 2'($urandom_range(0, 3));
                Stop2  = 1'($urandom_range(0, 1));
                @(negedge Clk);
            end
            send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        check("final_state", 32'(DbgState), 32'(IDLE));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a valid/ready input handshake, a one-entry holding register for back-to-back frames, runtime-selectable data length, parity and stop bits, and a synchronous oversampling tick enable. It sits between the NPU result path and the RS-232 pin and is the drop-in successor of the fixed 8N1 transmitter. It is fully synchronous to `Clk`; `Tick` is a clock enable, never a clock.

## Interface
- `DATA_W`, default 8: maximum data bits per frame; legal range 5..9.
- `OVS`, default 16: `Tick` pulses per bit period; legal range 4..64.
- `Clk`, input, 1: sole clock, rising edge.
- `Rst`, input, 1: asynchronous, active-high reset.
- `Tick`, input, 1: one-`Clk` pulse at OVS× baud rate.
- `TxData`, input, DATA_W: word to send, LSB first.
- `TxValid`, input, 1: `TxData` and config are valid.
- `TxReady`, output, 1: holding register empty; a transfer occurs when `TxValid & TxReady`.
- `NBits`, input, 4: data bits for this frame; sampled at transfer.
- `Parity`, input, 2: `00` none, `01` even, `10` odd, `11` none; sampled at transfer.
- `Stop2`, input, 1: 0 = one stop bit, 1 = two stop bits; sampled at transfer.
- `Tx`, output, 1: serial line, idles high.
- `Busy`, output, 1: a frame is on the line.
- `TxDone`, output, 1: one-`Clk` pulse at the end of each frame's last stop bit.

## Operation
- Holding register stores data, NBits, Parity and Stop2. `TxReady = !hold_full`.
- NBits is clamped to the range [5, DATA_W] at transfer. For example, with DATA_W = 8, NBits = 3 becomes 5 and NBits = 12 becomes 8.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `hold_full`, load the shifter from the hold register, clear `hold_full`, and go to START.
  - START: `Tx` = 0. Then go to DATA.
  - DATA: `Tx` = shifter[0]; shift right each bit. After NBits bits, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: `Tx` = XOR of the NBits data bits for even parity, or its inverse for odd parity.
  - STOP: `Tx` = 1 for 1 or 2 bit periods.
- Bit timing uses `tick_cnt`, which counts 0..OVS-1 on `Tick`.
  - The bit period ends on a `Tick` when `tick_cnt == OVS-1`.
  - `tick_cnt` clears to 0 on every shifter load.
- End of the last stop bit:
  - `TxDone` pulses for one cycle.
  - If `hold_full`, load the next frame and go directly to START with no idle bit.
  - Otherwise go to IDLE.
- Reset values: `Tx` = 1, `TxReady` = 1, `Busy` = 0, `TxDone` = 0, FSM = IDLE, `hold_full` = 0, `tick_cnt` = 0.

## Timing
- Transfer on edge n (FSM in IDLE): `hold_full` = 1 after edge n, and `TxReady` = 0 during cycle n+1.
  - On edge n+1 the shifter loads. From cycle n+2, `Tx` = 0, `Busy` = 1 and `TxReady` = 1.
- `Tx` is registered and glitch-free. It changes only on `Clk` edges.
- Each bit lasts from its load or advance edge until the OVS-th subsequent `Tick`. Every bit after the start bit is exactly OVS `Tick` periods.
- Frame length is 1 + NBits + (parity ? 1 : 0) + (Stop2 ? 2 : 1) bit periods.
- `TxDone` is asserted in the cycle after the edge that ends the last stop bit. In a back-to-back transfer, that same cycle shows `Tx` = 0 for the new start bit.
- Transfer in the same cycle as a hold-to-shifter load is impossible, because `TxReady` was 0 that cycle.
- Config inputs are ignored except at transfer. Changing them mid-frame has no effect.
- `Tick` with no frame in progress has no effect.
- `Rst` mid-frame: `Tx` = 1 immediately. The frame and the holding contents are discarded and `TxDone` is not pulsed.

## Structure
- Package `uart_pkg` holds:
  - enum `parity_e` (NONE, EVEN, ODD);
  - enum `tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_MIN_BITS` = 5 and `UART_MAX_BITS` = 9;
  - function `calc_parity(data, nbits, mode)`.
- One sub-module is natural: `uart_tx_hold`, the single-entry valid/ready holding register, which keeps the FSM file free of handshake logic.
- Include an elaboration-time check that DATA_W and OVS are within their legal ranges.

## Test plan
- 8N1 frame: send 0x55 with NBits = 8, Parity = 00, Stop2 = 0, `Tick` every 4 clocks.
  - Required: `Tx` = 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks.
  - One `TxDone` pulse, then `Busy` = 0.
- 7E2 frame: send 0x41 with NBits = 7, Parity = even, Stop2 = 1.
  - Required: 0, 1000001, parity 0, stop bits 1,1 (11 bits total).
  - Repeat with odd parity: the parity bit is 1.
- Back-to-back: assert 0xA5 and 0x3C in consecutive accepted handshakes.
  - Required: the second start bit immediately follows the first stop bit with no idle high.
  - `TxReady` is low from the second transfer until the second frame loads.
  - Two `TxDone` pulses.
- Backpressure: hold `TxValid` continuously with three words.
  - Required: `TxReady` gates every transfer, no word is lost or duplicated, and the line order is correct.
- NBits clamp: NBits = 3 with 0xFF must send 5 data ones. NBits = 15 with DATA_W = 8 must send 8 data bits.
- Reset mid-frame: assert `Rst` during bit 4 with a word held.
  - Required: `Tx` = 1 and `TxReady` = 1 immediately, no `TxDone`, and the next transfer sends a clean frame.
